// File: rtl/sram_arb_pkg.sv
// Shared types and the rotate-priority pick used by the SRAM port arbiter.
// SRAM_ARB_FIXED_PRIO_EN (see sram_port_arbiter) does not change anything here.
package sram_arb_pkg;

    localparam int unsigned SRAM_BMASK_W = 4;
    localparam int unsigned RR_MAX_N     = 8;
    localparam int unsigned RR_PTR_W     = 3;
    localparam int unsigned RR_SUM_W     = RR_PTR_W + 1;

    typedef enum logic [0:0] {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // First set bit of valid at or above ptr, wrapping modulo n; one-hot result.
    function automatic logic [RR_MAX_N-1:0] rr_pick(
        input logic [RR_MAX_N-1:0] valid,
        input logic [RR_PTR_W-1:0] ptr,
        input int unsigned         n
    );
        logic [RR_MAX_N-1:0] grant;
        logic                found;
        logic [RR_SUM_W-1:0] idx;
        grant = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < RR_MAX_N; i++) begin
            idx = {1'b0, ptr} + RR_SUM_W'(i);
            if (32'(idx) >= n) begin
                idx = idx - RR_SUM_W'(n);
            end
            if (!found && (i < n) && valid[idx[RR_PTR_W-1:0]]) begin
                grant[idx[RR_PTR_W-1:0]] = 1'b1;
                found                    = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/sram_arb_rr_picker.sv
// Combinational rotate-priority encoder: one-hot grant of the first valid
// requester at or after i_ptr. Holds no state.
module sram_arb_rr_picker
    import sram_arb_pkg::*;
#(
    parameter  int unsigned NREQ = 2,
    localparam int unsigned PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_valid,
    input  logic [PW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_grant
);

    always_comb begin
        o_grant = NREQ'(rr_pick(RR_MAX_N'(i_valid), RR_PTR_W'(i_ptr), NREQ));
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM port between NREQ valid/ready requesters with round-robin
// arbitration, optional timed lock, and 1-cycle response routing.
// Define SRAM_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned NREQ     = 2,
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned LOCK_MAX = 16
) (
    input  logic                           i_clk,
    input  logic                           i_reset_n,
    input  logic [NREQ-1:0]                i_req_valid,
    input  logic [NREQ*AW-1:0]             i_req_addr,
    input  logic [NREQ*DW-1:0]             i_req_wdata,
    input  logic [NREQ*SRAM_BMASK_W-1:0]   i_req_bmask,
    input  logic [NREQ-1:0]                i_req_wren,
    input  logic [NREQ-1:0]                i_req_lock,
    output logic [NREQ-1:0]                o_req_ready,
    output logic [NREQ-1:0]                o_rsp_valid,
    output logic [DW-1:0]                  o_rsp_rdata,
    output logic [AW-1:0]                  o_mem_addr,
    output logic [31:0]                    o_mem_wdata,
    output logic [SRAM_BMASK_W-1:0]        o_mem_bmask,
    output logic                           o_mem_wren,
    input  logic [31:0]                    i_mem_rdata
);

    localparam int unsigned PW  = $clog2(NREQ);
    localparam int unsigned LCW = $clog2(LOCK_MAX + 1);

    arb_state_e      state_q, state_d;
    logic [LCW-1:0]  lock_cnt_q, lock_cnt_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic            rsp_read_q, rsp_read_d;
`ifndef SRAM_ARB_FIXED_PRIO_EN
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
`endif

    logic [PW-1:0]   pick_ptr;
    logic [PW-1:0]   gidx;
    logic [NREQ-1:0] owner_mask;
    logic [NREQ-1:0] pick_valid;
    logic [NREQ-1:0] grant;
    logic            accept;
    logic            accept_lock;
    logic            accept_wren;

`ifdef SRAM_ARB_FIXED_PRIO_EN
    assign pick_ptr = '0;
`else
    assign pick_ptr = rr_ptr_q;
`endif

    // While locked, masking down to the owner lets the picker enforce exclusivity.
    always_comb begin
        owner_mask = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            owner_mask[k] = (owner_q == PW'(k));
        end
        pick_valid = (state_q == LOCKED) ? (i_req_valid & owner_mask) : i_req_valid;
    end

    sram_arb_rr_picker #(
        .NREQ (NREQ)
    ) u_picker (
        .i_valid (pick_valid),
        .i_ptr   (pick_ptr),
        .o_grant (grant)
    );

    assign o_req_ready = grant;

    always_comb begin
        gidx        = '0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_bmask = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (grant[k]) begin
                gidx        = PW'(k);
                o_mem_addr  = i_req_addr[k*AW +: AW];
                o_mem_wdata = 32'(i_req_wdata[k*DW +: DW]);
                o_mem_bmask = i_req_bmask[k*SRAM_BMASK_W +: SRAM_BMASK_W];
            end
        end
        accept      = |grant;
        accept_lock = |(grant & i_req_lock);
        accept_wren = |(grant & i_req_wren);
        o_mem_wren  = accept_wren;
    end

    always_comb begin
        state_d     = state_q;
        lock_cnt_d  = lock_cnt_q;
        owner_d     = owner_q;
`ifndef SRAM_ARB_FIXED_PRIO_EN
        rr_ptr_d    = rr_ptr_q;
`endif
        rsp_valid_d = grant;
        rsp_read_d  = accept & ~accept_wren;

        case (state_q)
            ARB: begin
                if (accept) begin
`ifndef SRAM_ARB_FIXED_PRIO_EN
                    rr_ptr_d = (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
`endif
                    if (accept_lock) begin
                        state_d    = LOCKED;
                        owner_d    = gidx;
                        lock_cnt_d = '0;
                    end
                end
            end
            LOCKED: begin
                if (lock_cnt_q != LCW'(LOCK_MAX)) begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end
                // An owner beat accepted in the timeout cycle is still serviced.
                if ((accept && !accept_lock) || (lock_cnt_q == LCW'(LOCK_MAX - 1))) begin
                    state_d = ARB;
`ifndef SRAM_ARB_FIXED_PRIO_EN
                    rr_ptr_d = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
`endif
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q     <= ARB;
            lock_cnt_q  <= '0;
            owner_q     <= '0;
            rsp_valid_q <= '0;
            rsp_read_q  <= 1'b0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
            rr_ptr_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            lock_cnt_q  <= lock_cnt_d;
            owner_q     <= owner_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_read_q  <= rsp_read_d;
`ifndef SRAM_ARB_FIXED_PRIO_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

    // SRAM holds o_rdata across a write, so write-acks must return zero data.
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_rdata = rsp_read_q ? DW'(i_mem_rdata) : '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter (default round-robin build) with a behavioural
// SRAM and a rule-level arbitration/response model.
module tb_sram_port_arbiter;

    localparam int unsigned NREQ     = 3;
    localparam int unsigned AW       = 8;
    localparam int unsigned DW       = 32;
    localparam int unsigned LOCK_MAX = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic [NREQ-1:0]    req_valid, req_wren, req_lock, req_ready, rsp_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ*4-1:0]  req_bmask;
    logic [DW-1:0]      rsp_rdata;
    logic [AW-1:0]      mem_addr;
    logic [31:0]        mem_wdata;
    logic [3:0]         mem_bmask;
    logic               mem_wren;
    logic [31:0]        mem_rdata = '0;

    logic          v  [NREQ];
    logic          w  [NREQ];
    logic          l  [NREQ];
    logic [AW-1:0] a  [NREQ];
    logic [31:0]   d  [NREQ];
    logic [3:0]    bm [NREQ];

    logic [31:0] sram    [256];
    logic [31:0] ref_mem [256];

    int m_ptr, m_owner, m_held;
    bit m_locked;
    bit p_valid, p_read;
    int p_req;
    logic [31:0] p_data;
    bit known;
    logic [NREQ-1:0] last_ready;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    always_comb begin
        req_valid = '0; req_wren = '0; req_lock = '0;
        req_addr  = '0; req_wdata = '0; req_bmask = '0;
        for (int k = 0; k < NREQ; k++) begin
            req_valid[k]          = v[k];
            req_wren[k]           = w[k];
            req_lock[k]           = l[k];
            req_addr[k*AW +: AW]  = a[k];
            req_wdata[k*DW +: DW] = d[k];
            req_bmask[k*4 +: 4]   = bm[k];
        end
    end

    always @(posedge clk) begin
        if (mem_wren) begin
            for (int b = 0; b < 4; b++)
                if (mem_bmask[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end else begin
            mem_rdata <= sram[mem_addr];
        end
    end

    sram_port_arbiter #(
        .NREQ     (NREQ),
        .AW       (AW),
        .DW       (DW),
        .LOCK_MAX (LOCK_MAX)
    ) dut (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .i_req_valid (req_valid),
        .i_req_addr  (req_addr),
        .i_req_wdata (req_wdata),
        .i_req_bmask (req_bmask),
        .i_req_wren  (req_wren),
        .i_req_lock  (req_lock),
        .o_req_ready (req_ready),
        .o_rsp_valid (rsp_valid),
        .o_rsp_rdata (rsp_rdata),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .o_mem_bmask (mem_bmask),
        .o_mem_wren  (mem_wren),
        .i_mem_rdata (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_all();
        for (int k = 0; k < NREQ; k++) begin
            v[k] = 1'b0; w[k] = 1'b0; l[k] = 1'b0;
            a[k] = '0;   d[k] = '0;   bm[k] = '0;
        end
    endtask

    task automatic drive(input int k, input bit wr, input int addr,
                         input logic [31:0] data, input logic [3:0] mask, input bit lock);
        v[k] = 1'b1; w[k] = wr; l[k] = lock;
        a[k] = AW'(addr); d[k] = data; bm[k] = mask;
    endtask

    // Whoever the rules say should own the port this cycle, or -1.
    function automatic int model_grant();
        if (m_locked) return v[m_owner] ? m_owner : -1;
        for (int i = 0; i < NREQ; i++) begin
            int k;
            k = (m_ptr + i) % NREQ;
            if (v[k]) return k;
        end
        return -1;
    endfunction

    task automatic cycle();
        int g;
        logic [NREQ-1:0] e_ready, e_rv;
        logic [31:0] e_addr, e_wd, e_rd;
        logic [3:0] e_bm;
        logic e_wr;
        bit n_pv, n_read;
        logic [31:0] n_data;
        #1;
        g = model_grant();
        e_ready = '0; e_addr = '0; e_wd = '0; e_bm = '0; e_wr = 1'b0;
        if (g >= 0) begin
            e_ready[g] = 1'b1;
            e_addr = 32'(a[g]); e_wd = d[g]; e_bm = bm[g]; e_wr = w[g];
        end
        e_rv = '0;
        if (p_valid) e_rv[p_req] = 1'b1;
        e_rd = (p_valid && p_read) ? p_data : 32'h0;
        last_ready = req_ready;
        if (known) begin
            chk("ready", 32'(req_ready), 32'(e_ready));
            chk("mem_wren", 32'(mem_wren), 32'(e_wr));
            chk("mem_addr", 32'(mem_addr), e_addr);
            chk("mem_wdata", mem_wdata, e_wd);
            chk("mem_bmask", 32'(mem_bmask), 32'(e_bm));
            chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
            chk("rsp_rdata", rsp_rdata, e_rd);
        end
        n_pv = 1'b0; n_read = 1'b0; n_data = '0;
        if (g >= 0) begin
            n_pv = 1'b1;
            n_read = !w[g];
            if (w[g]) begin
                for (int b = 0; b < 4; b++)
                    if (bm[g][b]) ref_mem[a[g]][8*b +: 8] = d[g][8*b +: 8];
            end else begin
                n_data = ref_mem[a[g]];
            end
        end
        if (!rst_n) begin
            m_locked = 1'b0; m_ptr = 0; m_owner = 0; m_held = 0;
            p_valid = 1'b0; p_read = 1'b0; p_req = 0; p_data = '0;
            known = 1'b1;
        end else begin
            p_valid = n_pv; p_read = n_read; p_req = g; p_data = n_data;
            if (!m_locked) begin
                if (g >= 0) begin
                    m_ptr = (g + 1) % NREQ;
                    if (l[g]) begin m_locked = 1'b1; m_owner = g; m_held = 0; end
                end
            end else begin
                m_held++;
                if ((g >= 0 && !l[g]) || m_held == LOCK_MAX) begin
                    m_locked = 1'b0;
                    m_ptr = (m_owner + 1) % NREQ;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        known = 1'b0; m_locked = 1'b0; m_ptr = 0; m_owner = 0; m_held = 0;
        p_valid = 1'b0; p_read = 1'b0; p_req = 0; p_data = '0;
        idle_all();
        @(posedge clk);
        #1;
        cycle();
        cycle();
        chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset_rsp_rdata", rsp_rdata, 32'h0);

        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            idle_all();
            drive(2, 1'b1, i, 32'hA5000000 + 32'(i) * 32'h00010101, 4'hF, 1'b0);
            cycle();
        end

        idle_all(); drive(0, 1'b1, 5, 32'hDEADBEEF, 4'hF, 1'b0); cycle();
        chk("wack_valid", 32'(rsp_valid), 32'h1);
        chk("wack_rdata", rsp_rdata, 32'h0);
        idle_all(); drive(0, 1'b0, 5, 32'h0, 4'h0, 1'b0); cycle();
        chk("rd5_valid", 32'(rsp_valid), 32'h1);
        chk("rd5_rdata", rsp_rdata, 32'hDEADBEEF);

        idle_all(); drive(1, 1'b1, 7, 32'hFFFFFFFF, 4'hF, 1'b0); cycle();
        idle_all(); drive(1, 1'b1, 7, 32'h1234ABCD, 4'b0011, 1'b0); cycle();
        idle_all(); drive(1, 1'b0, 7, 32'h0, 4'h0, 1'b0); cycle();
        chk("bmask_rd", rsp_rdata, 32'hFFFFABCD);

        idle_all(); drive(1, 1'b1, 9, 32'hCAFEF00D, 4'hF, 1'b0); cycle();
        idle_all(); drive(1, 1'b0, 9, 32'h0, 4'h0, 1'b0); cycle();
        chk("raw_rd", rsp_rdata, 32'hCAFEF00D);

        for (int i = 0; i < 4; i++) begin
            idle_all();
            drive(0, 1'b0, i, 32'h0, 4'h0, 1'b0);
            drive(1, 1'b0, i + 4, 32'h0, 4'h0, 1'b0);
            cycle();
            chk("alt_grant", 32'(last_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
        end

        idle_all(); drive(0, 1'b0, 3, 32'h0, 4'h0, 1'b0); cycle();
        for (int i = 0; i < 4; i++) begin
            idle_all();
            drive(0, 1'b0, 2, 32'h0, 4'h0, 1'b0);
            drive(1, 1'b1, 10 + i, 32'h5000 + 32'(i), 4'hF, (i < 2));
            cycle();
            chk("lock_grant", 32'(last_ready), (i < 3) ? 32'h2 : 32'h1);
        end

        idle_all(); drive(1, 1'b0, 4, 32'h0, 4'h0, 1'b0); cycle();
        for (int i = 0; i < 6; i++) begin
            idle_all();
            drive(0, 1'b0, 1, 32'h0, 4'h0, 1'b1);
            drive(1, 1'b0, 6, 32'h0, 4'h0, (i == 5));
            cycle();
            chk("timeout_grant", 32'(last_ready), (i < 5) ? 32'h1 : 32'h2);
        end

        idle_all();
        drive(0, 1'b0, 1, 32'h0, 4'h0, 1'b0);
        drive(1, 1'b0, 8, 32'h0, 4'h0, 1'b1);
        cycle();
        chk("locked_grant", 32'(last_ready), 32'h2);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        chk("rst_drop_rsp", 32'(rsp_valid), 32'h0);
        cycle();
        chk("rst_first_grant", 32'(last_ready), 32'h1);

        for (int n = 0; n < 400; n++) begin
            idle_all();
            for (int k = 0; k < NREQ; k++) begin
                if ($urandom_range(0, 2) != 0)
                    drive(k, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                          $urandom, 4'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0));
            end
            rst_n = ($urandom_range(0, 63) != 0);
            cycle();
        end
        rst_n = 1'b1;
        idle_all();
        cycle();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one port of the dual-port SRAM between NREQ requesters (e.g. fetch, LSU, debug/DMA) using a valid/ready handshake.
- Arbitration is round-robin. An optional lock holds the port for multi-beat sequences, with a timeout that forces release.
- Tracks the SRAM's 1-cycle registered read latency and routes the response back to the requester that issued it.
- Sits between the core memory clients and SRAM port A or B.

Parameters:
- NREQ, 2, number of requesters (legal range 2..8).
- AW, 32, word address width passed through to the SRAM.
- DW, 32, data width (SRAM is fixed at 32).
- LOCK_MAX, 16, maximum consecutive cycles one owner may hold a lock before forced release (must be >= 1).

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset_n  in  1  reset, synchronous, active-low.
- i_req_valid  in  NREQ  per-requester request valid.
- i_req_addr  in  NREQ*AW  per-requester word address; requester k occupies slice [k*AW +: AW].
- i_req_wdata  in  NREQ*DW  per-requester write data.
- i_req_bmask  in  NREQ*4  per-requester byte mask.
- i_req_wren  in  NREQ  1 = write, 0 = read.
- i_req_lock  in  NREQ  request to keep the grant after this beat.
- o_req_ready  out  NREQ  one-hot grant; a request is accepted when valid & ready.
- o_rsp_valid  out  NREQ  one-hot response strobe, one cycle after acceptance.
- o_rsp_rdata  out  DW  read data, shared by all requesters and qualified by o_rsp_valid.
- o_mem_addr  out  AW  to SRAM i_addr.
- o_mem_wdata  out  32  to SRAM i_wdata.
- o_mem_bmask  out  4  to SRAM i_bmask.
- o_mem_wren  out  1  to SRAM i_wren.
- i_mem_rdata  in  32  from SRAM o_rdata.

Behaviour:
- Reset (i_reset_n=0 at a clock edge): state=ARB, rr_ptr=0, lock_cnt=0, owner=0, o_rsp_valid=0, o_rsp_rdata=0. Reset mid-lock or with a response pending drops both; no response is issued afterwards.
- Grant is combinational in the same cycle. At most one bit of o_req_ready is set, and only when that requester's valid is also set. o_req_ready never asserts for an idle requester.
- State ARB:
  - Grant goes to the first valid requester, searching from rr_ptr upward with wrap modulo NREQ.
  - On acceptance, rr_ptr <= granted+1 (wrapping from NREQ-1 to 0).
  - With no acceptance, rr_ptr holds.
- ARB -> LOCKED: an accepted beat with i_req_lock[k]=1 sets owner<=k and lock_cnt<=0.
- State LOCKED:
  - Only the owner can be granted; other requesters stall.
  - lock_cnt increments every cycle in LOCKED, saturating at LOCK_MAX.
  - An accepted owner beat with lock=0 returns to ARB, with rr_ptr<=owner+1.
  - When lock_cnt reaches LOCK_MAX-1 and the owner has no lock=0 beat accepted, the state returns to ARB next cycle (forced release) and rr_ptr<=owner+1. The beat accepted in that last cycle is still serviced.
  - If the owner drops valid, the lock is kept until the timeout.
- SRAM command outputs:
  - When a grant exists, addr/wdata/bmask/wren are those of the granted requester, combinationally.
  - With no grant: o_mem_wren=0, o_mem_bmask=0, o_mem_addr=0, o_mem_wdata=0.
- Response:
  - A beat accepted in cycle t gives o_rsp_valid[k]=1 for exactly cycle t+1.
  - Reads: o_rsp_rdata=i_mem_rdata. Writes: o_rsp_valid still asserts as a write-ack, with o_rsp_rdata=0, because the SRAM holds o_rdata during writes.
  - Back-to-back beats are supported: one acceptance per cycle, with full throughput.
- Read-after-write to the same address in consecutive cycles returns the new data, since the SRAM write commits at edge t.

Optional Feature:
- Macro: SRAM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; rr_ptr is removed. Lock and timeout are unchanged; on release, arbitration restarts from index 0.
- Undefined: round-robin as specified above.

Decomposition:
- Package sram_arb_pkg:
  - typedef arb_state_e {ARB, LOCKED}.
  - Function rr_pick(valid, ptr) returning a one-hot grant.
  - Localparam SRAM_BMASK_W=4.
- Sub-module sram_arb_rr_picker: combinational rotate-priority encoder, reused elsewhere. All state stays in sram_port_arbiter.

Test Plan:
- Single requester 0 reads addr 5 after mem[5]=0xDEADBEEF is written via the port -> write-ack at t+1 with rdata=0; read gives o_rsp_valid=0b01 and o_rsp_rdata=0xDEADBEEF at t+1.
- Requesters 0 and 1 both valid continuously for 4 cycles -> grants 0,1,0,1; each response lands one cycle after its grant on the matching o_rsp_valid bit.
- Requester 1 locks for 3 beats while 0 is valid -> 0 stalls 3 cycles. Beat 3 carries lock=0 -> 0 is granted the next cycle.
- LOCK_MAX=4, requester 0 holds lock=1 and requester 1 is waiting -> forced release after 4 locked cycles; requester 1 is granted in cycle 5.
- i_reset_n low for one cycle while LOCKED and a response is pending -> o_rsp_valid=0 and state=ARB next cycle; the first grant goes to requester 0.
- Byte-masked write to addr 7: bmask=0b0011, wdata=0x1234ABCD over 0xFFFFFFFF, then read -> 0xFFFFABCD.
